stl_uart_packetizer: RTL and testbench
======================================

STL_UART_PACKETIZER -- requirements
Module: stl_uart_packetizer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other timing is synchronous to the rising edge of clk.
REQ-002 Parameter PACKET_BYTES, default 16, sets the packet length in bytes (legal range 2..32).
REQ-003 Parameter TIMEOUT_CYCLES, default 100_000, sets the inter-byte idle limit in clk cycles (legal value is at least 2).
REQ-004 Parameter RSP_DEPTH, default 2, sets the response FIFO depth in packets (power of 2, at least 2).
REQ-005 Ports SHALL be as follows (W = 8*PACKET_BYTES):
  clk  in  1  clock
  reset_n  in  1  async active-low reset
  data_valid  in  1  UART RX byte valid
  data_ready  out  1  RX byte accepted when high with data_valid
  data_in  in  8  UART RX byte
  packet_valid  out  1  assembled request valid
  packet_ready  in  1  bridge accepts request
  packet_data  out  W  assembled request
  tl_response_valid  in  1  TileLink response valid
  tl_response_ready  out  1  response FIFO not full
  tl_response_data  in  W  TileLink response packet
  response_valid  out  1  UART TX byte valid
  response_ready  in  1  UART TX accepts byte
  response_data  out  8  UART TX byte
  timeout_pulse  out  1  one-cycle pulse when a partial packet is dropped
  timeout_count  out  8  saturating count of dropped partial packets

Function
REQ-006 The RX assembler SHALL use three states: RX_IDLE, RX_ACTIVE and RX_HOLD.
REQ-007 data_ready SHALL be high in RX_IDLE and RX_ACTIVE, and low in RX_HOLD.
REQ-008 A byte transfer SHALL occur on any cycle where data_valid and data_ready are both high.
REQ-009 The k-th accepted byte (k = 0..PACKET_BYTES-1) SHALL be written to packet_data[8k+7:8k], so the first byte lands at the LSB.
REQ-010 RX transitions SHALL be:
  - RX_IDLE to RX_ACTIVE on the first byte transfer.
  - RX_ACTIVE to RX_HOLD on transfer of byte index PACKET_BYTES-1.
  - RX_HOLD to RX_IDLE on the packet_valid and packet_ready handshake.
REQ-011 packet_valid SHALL be high exactly while in RX_HOLD, rising the cycle after the last byte transfer.
REQ-012 packet_data SHALL stay stable while packet_valid is high.
REQ-013 data_ready SHALL rise the cycle after the request handshake.
REQ-014 The byte index counter SHALL be $clog2(PACKET_BYTES) bits wide, and SHALL clear on entry to RX_IDLE.
REQ-015 In RX_ACTIVE, the idle counter SHALL increment each cycle with no byte transfer, and clear on every byte transfer.
REQ-016 When the idle counter reaches TIMEOUT_CYCLES-1 with no transfer, the block SHALL:
  - discard the partial packet;
  - return to RX_IDLE;
  - pulse timeout_pulse for one cycle;
  - increment timeout_count, saturating at 255.
REQ-017 A byte transfer on the timeout cycle SHALL take priority; no timeout occurs on that cycle.
REQ-018 The idle counter SHALL not run in RX_IDLE or RX_HOLD.
REQ-019 The RX path SHALL be independent of the TX path, so a new request can be assembled while responses stream.
REQ-020 Response FIFO: RSP_DEPTH entries of W bits.
  - tl_response_ready = !full.
  - A push occurs on tl_response_valid and tl_response_ready.
  - A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-021 The TX streamer SHALL use two states: TX_IDLE and TX_STREAM.
REQ-022 In TX_IDLE with the FIFO non-empty, the streamer SHALL pop the head into the shift register and enter TX_STREAM; response_valid rises the next cycle.
REQ-023 In TX_STREAM, response_data SHALL be shift-register bits [7:0], i.e. the response is sent LSB byte first.
REQ-024 response_valid and response_data SHALL stay stable until the response_ready handshake.
REQ-025 On each TX handshake the shift register SHALL shift right by 8.
REQ-026 On the handshake of byte PACKET_BYTES-1 with the FIFO non-empty, the streamer SHALL pop the next packet on the same edge. response_valid stays high with no bubble.
REQ-027 On the handshake of byte PACKET_BYTES-1 with the FIFO empty, the streamer SHALL return to TX_IDLE.
REQ-028 Requests and responses SHALL not be correlated; ordering SHALL be preserved within each direction.

Reset
REQ-029 reset_n low SHALL asynchronously force:
  - RX_IDLE and TX_IDLE;
  - FIFO empty and all counters cleared;
  - packet_valid=0, packet_data=0;
  - response_valid=0, response_data=0;
  - timeout_pulse=0, timeout_count=0.
REQ-030 While reset_n is low and after release, data_ready SHALL be 1 and tl_response_ready SHALL be 1.
REQ-031 Reset asserted mid-packet or mid-stream SHALL discard all partial and queued data, with no further output activity.

Verification
REQ-032 Bytes 0x00..0x0F at PACKET_BYTES=16, with packet_ready tied high, SHALL give packet_valid for 1 cycle and packet_data = 0x0F0E...0100.
REQ-033 One response packet 0x0F0E...0100 with response_ready tied high SHALL give response_data 0x00, 0x01, ..., 0x0F on 16 consecutive cycles.
REQ-034 Two back-to-back tl_response packets SHALL stream as 32 contiguous valid bytes. A third packet SHALL see tl_response_ready=0 until the first pop.
REQ-035 With TIMEOUT_CYCLES=8, sending 5 bytes then idling 8 cycles SHALL give timeout_pulse=1 once and timeout_count=1. A following 16 fresh bytes SHALL form a correct packet.
REQ-036 Holding packet_ready=0 for 20 cycles after a packet SHALL keep data_ready=0 and packet_data stable, with no timeout.
REQ-037 Pulsing reset_n low mid-stream at byte 7 SHALL make response_valid=0 immediately; with nothing pushed after release, response_valid SHALL stay 0.

Source files
------------

// File: rtl/stl_uart_packetizer.sv
// UART-to-TileLink packetizer: assembles RX bytes into fixed-length request packets
// and streams queued TileLink response packets back out as UART bytes, LSB byte first.
module stl_uart_packetizer #(
  parameter int PACKET_BYTES   = 16,
  parameter int TIMEOUT_CYCLES = 100_000,
  parameter int RSP_DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic [7:0]                data_in,
  output logic                      packet_valid,
  input  logic                      packet_ready,
  output logic [8*PACKET_BYTES-1:0] packet_data,
  input  logic                      tl_response_valid,
  output logic                      tl_response_ready,
  input  logic [8*PACKET_BYTES-1:0] tl_response_data,
  output logic                      response_valid,
  input  logic                      response_ready,
  output logic [7:0]                response_data,
  output logic                      timeout_pulse,
  output logic [7:0]                timeout_count
);

  localparam int W      = 8 * PACKET_BYTES;
  localparam int IDX_W  = $clog2(PACKET_BYTES);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam int PTR_W  = $clog2(RSP_DEPTH);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PACKET_BYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]    FIFO_FULL  = (PTR_W + 1)'(RSP_DEPTH);

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_ACTIVE = 2'd1;
  localparam logic [1:0] RX_HOLD   = 2'd2;

  localparam logic [0:0] TX_IDLE   = 1'b0;
  localparam logic [0:0] TX_STREAM = 1'b1;

  // ---------------------------------------------------------------- RX assembler
  logic [1:0]        r_rx_state;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [W-1:0]      r_pkt;
  logic              r_to_pulse;
  logic [7:0]        r_to_count;
  logic              w_rx_xfer;

  assign data_ready    = (r_rx_state != RX_HOLD);
  assign w_rx_xfer     = data_valid && data_ready;
  assign packet_valid  = (r_rx_state == RX_HOLD);
  assign packet_data   = r_pkt;
  assign timeout_pulse = r_to_pulse;
  assign timeout_count = r_to_count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state <= RX_IDLE;
      r_byte_idx <= '0;
      r_idle_cnt <= '0;
      r_pkt      <= '0;
      r_to_pulse <= 1'b0;
      r_to_count <= '0;
    end else begin
      r_to_pulse <= 1'b0;
      case (r_rx_state)
        RX_IDLE, RX_ACTIVE: begin
          if (w_rx_xfer) begin
            r_pkt[{r_byte_idx, 3'b000} +: 8] <= data_in;
            r_idle_cnt <= '0;
            if (r_byte_idx == LAST_IDX) begin
              r_byte_idx <= '0;
              r_rx_state <= RX_HOLD;
            end else begin
              r_byte_idx <= r_byte_idx + IDX_W'(1);
              r_rx_state <= RX_ACTIVE;
            end
          end else if (r_rx_state == RX_ACTIVE) begin
            // A transfer on the limit cycle wins; only a silent limit cycle drops the packet.
            if (r_idle_cnt == IDLE_LIMIT) begin
              r_rx_state <= RX_IDLE;
              r_byte_idx <= '0;
              r_idle_cnt <= '0;
              r_to_pulse <= 1'b1;
              if (r_to_count != 8'hFF) r_to_count <= r_to_count + 8'd1;
            end else begin
              r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end
          end
        end
        RX_HOLD: begin
          if (packet_ready) begin
            r_rx_state <= RX_IDLE;
            r_byte_idx <= '0;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- response FIFO
  logic [W-1:0]     r_mem [RSP_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full            = (r_count == FIFO_FULL);
  assign w_empty           = (r_count == '0);
  assign tl_response_ready = !w_full;
  assign w_push            = tl_response_valid && !w_full;

  // NOTE: storage is left unreset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tl_response_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- TX streamer
  logic [0:0]       r_tx_state;
  logic [W-1:0]     r_shift;
  logic [IDX_W-1:0] r_tx_cnt;
  logic             w_tx_hs;
  logic             w_tx_last;

  assign response_valid = (r_tx_state == TX_STREAM);
  assign response_data  = r_shift[7:0];
  assign w_tx_hs        = response_valid && response_ready;
  assign w_tx_last      = w_tx_hs && (r_tx_cnt == LAST_IDX);
  // Reloading on the last handshake keeps back-to-back responses bubble-free.
  assign w_pop          = !w_empty && ((r_tx_state == TX_IDLE) || w_tx_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_shift    <= '0;
      r_tx_cnt   <= '0;
    end else if (w_pop) begin
      r_shift    <= r_mem[r_rd_ptr];
      r_tx_cnt   <= '0;
      r_tx_state <= TX_STREAM;
    end else if (w_tx_hs) begin
      r_shift <= {8'h00, r_shift[W-1:8]};
      if (w_tx_last) begin
        r_tx_cnt   <= '0;
        r_tx_state <= TX_IDLE;
      end else begin
        r_tx_cnt <= r_tx_cnt + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stl_uart_packetizer.sv
// Self-checking bench for stl_uart_packetizer: directed table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_stl_uart_packetizer;

  localparam int PB    = 16;
  localparam int TO    = 8;
  localparam int DEPTH = 2;
  localparam int W     = 8 * PB;
  localparam logic [W-1:0] PKT_RAMP = 128'h0F0E0D0C0B0A09080706050403020100;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic [7:0]   data_in = '0;
  logic         packet_valid;
  logic         packet_ready = 1'b0;
  logic [W-1:0] packet_data;
  logic         tl_response_valid = 1'b0;
  logic         tl_response_ready;
  logic [W-1:0] tl_response_data = '0;
  logic         response_valid;
  logic         response_ready = 1'b0;
  logic [7:0]   response_data;
  logic         timeout_pulse;
  logic [7:0]   timeout_count;

  always #5 clk = ~clk;

  stl_uart_packetizer #(
    .PACKET_BYTES  (PB),
    .TIMEOUT_CYCLES(TO),
    .RSP_DEPTH     (DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .data_in          (data_in),
    .packet_valid     (packet_valid),
    .packet_ready     (packet_ready),
    .packet_data      (packet_data),
    .tl_response_valid(tl_response_valid),
    .tl_response_ready(tl_response_ready),
    .tl_response_data (tl_response_data),
    .response_valid   (response_valid),
    .response_ready   (response_ready),
    .response_data    (response_data),
    .timeout_pulse    (timeout_pulse),
    .timeout_count    (timeout_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef logic [7:0] byte_q_t[$];

  function automatic logic [W-1:0] pack(input byte_q_t q);
    logic [W-1:0] v = '0;
    for (int k = 0; k < q.size(); k++) v[k*8 +: 8] = q[k];
    return v;
  endfunction

  // Expected TX byte stream plus handshake bookkeeping for contiguity checks.
  byte_q_t tx_exp;
  int      cyc = 0;
  int      hs_count = 0;
  int      first_hs = -1;
  int      last_hs = -1;

  task automatic enqueue_rsp(input logic [W-1:0] p);
    for (int k = 0; k < PB; k++) tx_exp.push_back(p[k*8 +: 8]);
  endtask

  task automatic mark_tx();
    hs_count = 0;
    first_hs = -1;
    last_hs  = -1;
  endtask

  task automatic wait_tx_drain(input int budget);
    int c = 0;
    while (tx_exp.size() != 0 && c < budget) begin
      @(negedge clk); #3;
      c++;
    end
    check("tx_drain_left", tx_exp.size(), 0);
  endtask

  // TX monitor: samples 2 time units after each falling edge.
  initial begin
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("tx_hold_valid", response_valid, 1);
          check("tx_hold_data", response_data, prev_data);
        end
        if (response_valid && response_ready) begin
          if (tx_exp.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL tx_unexpected_byte: got %0h, expected no byte", response_data);
          end else begin
            check("tx_byte", response_data, tx_exp.pop_front());
          end
          hs_count++;
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
        end
        prev_stall = response_valid && !response_ready;
        prev_data  = response_data;
      end
    end
  end

  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic       exp_dr;
    logic       exp_pv;
    logic       exp_pulse;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic dv, input logic [7:0] d, input logic ep, input logic [7:0] ec);
    vec_t v;
    v.dv = dv; v.din = d; v.exp_dr = 1'b1; v.exp_pv = 1'b0; v.exp_pulse = ep; v.exp_cnt = ec;
    tbl.push_back(v);
  endtask

  task automatic send_bytes(input logic [W-1:0] p, input logic pready);
    for (int i = 0; i < PB; i++) begin
      @(negedge clk);
      data_valid   = 1'b1;
      data_in      = p[i*8 +: 8];
      packet_ready = pready;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] p;
    // Timeout table: 5 bytes, 7 idle, a byte on the limit cycle, 8 idle, then settle.
    for (int i = 0; i < 5; i++) add(1'b1, 8'(8'hA0 + i), 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) add(1'b0, 8'h00, 1'b0, 8'd0);
    add(1'b1, 8'hB0, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) add(1'b0, 8'h00, 1'b0, 8'd0);
    add(1'b0, 8'h00, 1'b1, 8'd1);
    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b0, 8'd1);

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_data_ready", data_ready, 1);
    check("rst_tl_ready", tl_response_ready, 1);
    check("rst_pkt_valid", packet_valid, 0);
    check("rst_pkt_data", packet_data, 0);
    check("rst_rsp_valid", response_valid, 0);
    check("rst_rsp_data", response_data, 0);
    check("rst_to_pulse", timeout_pulse, 0);
    check("rst_to_count", timeout_count, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      check($sformatf("tbl%0d_data_ready", i), data_ready, tbl[i].exp_dr);
      check($sformatf("tbl%0d_pkt_valid", i), packet_valid, tbl[i].exp_pv);
      check($sformatf("tbl%0d_to_pulse", i), timeout_pulse, tbl[i].exp_pulse);
      check($sformatf("tbl%0d_to_count", i), timeout_count, tbl[i].exp_cnt);
      data_valid = tbl[i].dv;
      data_in    = tbl[i].din;
    end

    // Ramp packet after the dropped partial, consumer always ready.
    send_bytes(PKT_RAMP, 1'b1);
    @(negedge clk);
    data_valid = 1'b0;
    check("ramp_pkt_valid", packet_valid, 1);
    check("ramp_pkt_data", packet_data, PKT_RAMP);
    @(negedge clk);
    check("ramp_pkt_valid_drop", packet_valid, 0);
    check("ramp_data_ready", data_ready, 1);

    // Back-pressured request: held for 20 cycles with bytes still offered.
    p = {$urandom, $urandom, $urandom, $urandom};
    send_bytes(p, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = 8'h55;
      check("hold_data_ready", data_ready, 0);
      check("hold_pkt_valid", packet_valid, 1);
      check("hold_pkt_data", packet_data, p);
      check("hold_to_pulse", timeout_pulse, 0);
    end
    @(negedge clk);
    data_valid   = 1'b0;
    packet_ready = 1'b1;
    check("hold_last_pkt_valid", packet_valid, 1);
    @(negedge clk);
    packet_ready = 1'b0;
    check("hold_release_ready", data_ready, 1);
    check("hold_release_valid", packet_valid, 0);
    check("hold_to_count", timeout_count, 1);

    // Single response packet, TX always ready.
    mark_tx();
    response_ready = 1'b1;
    @(negedge clk);
    check("rsp1_tl_ready", tl_response_ready, 1);
    tl_response_valid = 1'b1;
    tl_response_data  = PKT_RAMP;
    enqueue_rsp(PKT_RAMP);
    @(negedge clk);
    tl_response_valid = 1'b0;
    wait_tx_drain(100);
    check("rsp1_hs_count", hs_count, 16);
    check("rsp1_span", last_hs - first_hs, 15);
    @(negedge clk); #3;
    check("rsp1_valid_after", response_valid, 0);

    // Three back-to-back responses: FIFO fills, then 48 contiguous bytes.
    mark_tx();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rsp3_tl_ready_pre", tl_response_ready, 1);
      p = {$urandom, $urandom, $urandom, $urandom};
      tl_response_valid = 1'b1;
      tl_response_data  = p;
      enqueue_rsp(p);
    end
    @(negedge clk);
    tl_response_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("rsp3_tl_ready_full", tl_response_ready, 0);
      @(negedge clk);
    end
    wait_tx_drain(200);
    check("rsp3_hs_count", hs_count, 48);
    check("rsp3_span", last_hs - first_hs, 47);
    @(negedge clk); #3;
    check("rsp3_tl_ready_post", tl_response_ready, 1);
    check("rsp3_valid_after", response_valid, 0);

    // Randomized run against the reference model.
    begin
      byte_q_t rx_q;
      bit      holding = 1'b0;
      int      idle = 0;
      bit      exp_pulse = 1'b0;
      int      exp_cnt = 1;  // one timeout already taken by the table
      int      gap = 0;
      bit      drain;
      for (int n = 0; n < 900; n++) begin
        @(negedge clk);
        check("rnd_data_ready", data_ready, !holding);
        check("rnd_pkt_valid", packet_valid, holding);
        if (holding) check("rnd_pkt_data", packet_data, pack(rx_q));
        check("rnd_to_pulse", timeout_pulse, exp_pulse);
        check("rnd_to_count", timeout_count, 8'(exp_cnt));

        if (gap > 0) begin
          data_valid = 1'b0;
          gap--;
        end else if ($urandom_range(0, 39) == 0) begin
          gap = $urandom_range(4, 12);
          data_valid = 1'b0;
        end else begin
          data_valid = ($urandom_range(0, 3) != 0);
        end
        data_in      = 8'($urandom);
        packet_ready = ($urandom_range(0, 2) == 0);

        exp_pulse = 1'b0;
        if (holding) begin
          if (packet_ready) begin
            holding = 1'b0;
            rx_q.delete();
          end
        end else if (data_valid) begin
          rx_q.push_back(data_in);
          idle = 0;
          if (rx_q.size() == PB) holding = 1'b1;
        end else if (rx_q.size() != 0) begin
          if (idle == TO - 1) begin
            rx_q.delete();
            idle = 0;
            exp_pulse = 1'b1;
            if (exp_cnt < 255) exp_cnt++;
          end else begin
            idle++;
          end
        end

        drain = (n >= 750);
        tl_response_valid = !drain && ($urandom_range(0, 1) == 1);
        tl_response_data  = {$urandom, $urandom, $urandom, $urandom};
        if (tl_response_valid && tl_response_ready) enqueue_rsp(tl_response_data);
        response_ready = drain || ($urandom_range(0, 9) < 6);
      end
      @(negedge clk);
      tl_response_valid = 1'b0;
      data_valid        = 1'b0;
      packet_ready      = 1'b1;
      response_ready    = 1'b1;
      wait_tx_drain(200);
    end

    // Reset mid-packet and mid-stream at byte 7.
    @(negedge clk);
    packet_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      data_valid = 1'b1;
      data_in    = 8'(8'hC0 + i);
    end
    @(negedge clk);
    data_valid = 1'b0;
    mark_tx();
    p = {$urandom, $urandom, $urandom, $urandom};
    tl_response_valid = 1'b1;
    tl_response_data  = p;
    enqueue_rsp(p);
    @(negedge clk);
    tl_response_valid = 1'b0;
    begin
      int c = 0;
      while (hs_count < 7 && c < 100) begin
        @(negedge clk); #3;
        c++;
      end
    end
    check("rst_mid_reached_byte7", hs_count, 7);
    reset_n = 1'b0;
    tx_exp.delete();
    #1;
    check("rst_mid_rsp_valid", response_valid, 0);
    check("rst_mid_rsp_data", response_data, 0);
    check("rst_mid_pkt_valid", packet_valid, 0);
    check("rst_mid_pkt_data", packet_data, 0);
    check("rst_mid_data_ready", data_ready, 1);
    check("rst_mid_tl_ready", tl_response_ready, 1);
    check("rst_mid_to_count", timeout_count, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #3;
      check("post_rst_rsp_valid", response_valid, 0);
    end
    send_bytes(PKT_RAMP, 1'b1);
    @(negedge clk);
    data_valid = 1'b0;
    check("post_rst_pkt_valid", packet_valid, 1);
    check("post_rst_pkt_data", packet_data, PKT_RAMP);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
